// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared types and defaults for the CPU run controller.
//               Run-mode and controller-state enums, default parameter
//               values and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Board mode switch encoding
    typedef enum logic [1:0] {
        MODE_HALT = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_STEP = 2'd3
    } run_mode_t;

    // Controller state encoding, visible on the state output
    typedef enum logic [2:0] {
        ST_HALT = 3'd0,
        ST_RUN  = 3'd1,
        ST_SLOW = 3'd2,
        ST_STEP = 3'd3,
        ST_BRK  = 3'd4,
        ST_DONE = 3'd5
    } ctrl_state_t;

    localparam int c_DEF_DIV_PERIOD = 50000000;
    localparam int c_DEF_DEB_CYCLES = 500000;
    localparam int c_DEF_CNT_W      = 32;

    // States in which the pipeline is not being advanced on its own
    function automatic logic is_halted_state(input ctrl_state_t s);
        logic r;
        r = (s == ST_HALT) || (s == ST_BRK) || (s == ST_DONE);
        return r;
    endfunction

    // State requested by the mode switch when nothing else overrides it
    function automatic ctrl_state_t mode_to_state(input run_mode_t m);
        ctrl_state_t r;
        case (m)
            MODE_RUN:  r = ST_RUN;
            MODE_SLOW: r = ST_SLOW;
            MODE_STEP: r = ST_STEP;
            default:   r = ST_HALT;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Synchronizes a raw active-low push button and emits a
//               single-cycle pulse for each accepted press (1->0 transition
//               that stayed stable for DEB_CYCLES synchronized samples).
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import cpu_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = c_DEF_DEB_CYCLES
)(
    input  logic clk,
    input  logic reset_n,
    input  logic raw_n_i,
    output logic press_pulse_o
);

    localparam int              c_CW   = $clog2(DEB_CYCLES + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DEB_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [c_CW-1:0] cnt_q,   cnt_d;
    logic            press_q, press_d;

    // Two-flop synchronizer; the button idles released (high) out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= raw_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the accepted level and
    // adopt the new level once the run is long enough
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == c_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
            press_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_pulse_o = press_q;

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Single-clock execution controller for the pipeline. Produces
//               the registered pipeline clock enable for HALT / RUN / SLOW /
//               STEP modes, stops on program end or PC breakpoint and counts
//               issued enables.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DIV_PERIOD = c_DEF_DIV_PERIOD,
    parameter int DEB_CYCLES = c_DEF_DEB_CYCLES,
    parameter int CNT_W      = c_DEF_CNT_W
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       mode_i,
    input  logic             step_btn_n_i,
    input  logic             bp_en_i,
    input  logic [31:0]      bp_addr_i,
    input  logic [31:0]      pc_i,
    input  logic             endcontrol_i,
    input  logic             clr_cnt_i,
    output logic             cpu_ce_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [2:0]       state_o,
    output logic             halted_o,
    output logic             bp_hit_o
);

    localparam int              c_DW       = $clog2(DIV_PERIOD);
    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(DIV_PERIOD - 1);

    ctrl_state_t      state_q, state_d;
    logic             ce_q,    ce_d;
    logic [c_DW-1:0]  div_q,   div_d;
    logic             skip_q,  skip_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    run_mode_t        w_mode;
    logic             w_press;
    logic             w_active;
    logic             w_bp_cond;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_step_deb (
        .clk           (clk),
        .reset_n       (reset_n),
        .raw_n_i       (step_btn_n_i),
        .press_pulse_o (w_press)
    );

    assign w_mode    = run_mode_t'(mode_i);
    assign w_active  = (state_q == ST_RUN) || (state_q == ST_SLOW) ||
                       (state_q == ST_STEP);
    // bp_skip masks the breakpoint we just stopped on until one enable has
    // been issued, so execution can step past it
    assign w_bp_cond = w_active && bp_en_i && (pc_i == bp_addr_i) && !skip_q;

    // Next state and next clock-enable decision; end and breakpoint override
    // everything and suppress the enable in their detection cycle
    always_comb begin
        state_d = state_q;
        ce_d    = 1'b0;
        div_d   = '0;
        if (state_q == ST_DONE || endcontrol_i) begin
            state_d = ST_DONE;
        end else if (w_bp_cond) begin
            state_d = ST_BRK;
        end else if (state_q == ST_BRK) begin
            if (w_mode == MODE_HALT) begin
                state_d = ST_HALT;
            end else if (w_press) begin
                ce_d = 1'b1;
                if (w_mode == MODE_STEP) begin
                    state_d = ST_STEP;
                end
            end
        end else begin
            state_d = mode_to_state(w_mode);
            case (state_q)
                ST_RUN: begin
                    ce_d = 1'b1;
                end
                ST_SLOW: begin
                    ce_d  = (div_q == c_DIV_LAST);
                    div_d = ce_d ? '0 : div_q + 1'b1;
                end
                ST_STEP: begin
                    ce_d = w_press;
                end
                default: begin
                    ce_d = 1'b0;
                end
            endcase
        end
    end

    // Breakpoint skip flag: armed on BRK entry, released by the next enable
    always_comb begin
        skip_d = skip_q;
        if (state_d == ST_BRK && state_q != ST_BRK) begin
            skip_d = 1'b1;
        end else if (ce_q) begin
            skip_d = 1'b0;
        end
    end

    // Saturating count of issued enables; clear has priority
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (ce_q && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Controller state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_HALT;
            ce_q    <= 1'b0;
            div_q   <= '0;
            skip_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ce_q    <= ce_d;
            div_q   <= div_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cpu_ce_o      = ce_q;
    assign cycle_count_o = cnt_q;
    assign state_o       = state_q;
    assign halted_o      = is_halted_state(state_q);
    assign bp_hit_o      = (state_q == ST_BRK);

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Self-checking bench for cpu_run_ctrl: directed scenarios
//               followed by randomized stimulus against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int DIV   = 4;
    localparam int DEB   = 3;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       mode;
    logic             step_btn_n;
    logic             bp_en;
    logic [31:0]      bp_addr;
    logic [31:0]      pc;
    logic             endcontrol;
    logic             clr_cnt;
    logic             cpu_ce;
    logic [CNT_W-1:0] cycle_count;
    logic [2:0]       state;
    logic             halted;
    logic             bp_hit;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ce_seen  = 0;
    int last_ce  = 0;
    int ce_gap   = 0;
    bit pc_follow = 0;

    cpu_run_ctrl #(
        .DIV_PERIOD (DIV),
        .DEB_CYCLES (DEB),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mode_i        (mode),
        .step_btn_n_i  (step_btn_n),
        .bp_en_i       (bp_en),
        .bp_addr_i     (bp_addr),
        .pc_i          (pc),
        .endcontrol_i  (endcontrol),
        .clr_cnt_i     (clr_cnt),
        .cpu_ce_o      (cpu_ce),
        .cycle_count_o (cycle_count),
        .state_o       (state),
        .halted_o      (halted),
        .bp_hit_o      (bp_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // States as plain integers: 0 halt, 1 run, 2 slow, 3 step, 4 brk, 5 done
    int m_state, m_cnt, m_slowk, m_run;
    bit m_ce, m_skip, m_level, m_press, m_s1, m_s2;

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_slowk = 0; m_run = 0;
        m_ce = 0; m_skip = 0; m_level = 1; m_press = 0; m_s1 = 1; m_s2 = 1;
    endtask

    task automatic model_step();
        int ns, ncnt, nk, nrun;
        bit nce, nskip, nlevel, npress, bpc;
        ncnt = clr_cnt ? 0 : (m_ce ? ((m_cnt < MAXC) ? m_cnt + 1 : MAXC) : m_cnt);
        bpc  = (m_state >= 1 && m_state <= 3) && bp_en && (pc == bp_addr) && !m_skip;
        ns = m_state; nce = 0;
        if (m_state == 5 || endcontrol) ns = 5;
        else if (bpc) ns = 4;
        else if (m_state == 4) begin
            if (mode == 2'd0) ns = 0;
            else if (m_press) begin
                nce = 1;
                if (mode == 2'd3) ns = 3;
            end
        end else begin
            ns = int'(mode);
            if (m_state == 1) nce = 1;
            if (m_state == 2) nce = ((m_slowk % DIV) == DIV - 1);
            if (m_state == 3) nce = m_press;
        end
        // SLOW cycles counted from entry; any exit restarts the count
        nk = (m_state == 2 && ns == 2) ? m_slowk + 1 : 0;
        nskip = (ns == 4 && m_state != 4) ? 1'b1 : (m_ce ? 1'b0 : m_skip);
        // debounce: accept a level after DEB consecutive disagreeing samples
        nlevel = m_level; npress = 0; nrun = 0;
        if (m_s2 != m_level) begin
            nrun = m_run + 1;
            if (nrun == DEB) begin
                nlevel = m_s2; npress = !m_s2; nrun = 0;
            end
        end
        m_state = ns; m_ce = nce; m_cnt = ncnt; m_slowk = nk; m_skip = nskip;
        m_level = nlevel; m_press = npress; m_run = nrun;
        m_s2 = m_s1; m_s1 = step_btn_n;
    endtask

    // One clock: step model on the edge, compare #1 later
    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
        cyc++;
        check("model_ce",     cpu_ce,      m_ce);
        check("model_cnt",    cycle_count, m_cnt);
        check("model_state",  state,       m_state);
        check("model_halted", halted,      (m_state == 0 || m_state >= 4));
        check("model_bp_hit", bp_hit,      (m_state == 4));
        if (cpu_ce) begin
            ce_seen++;
            ce_gap  = cyc - last_ce;
            last_ce = cyc;
            if (pc_follow) pc = (pc + 32'd4) & 32'h3C;
        end
    endtask

    task automatic apply_reset();
        reset_n = 0; mode = 0; step_btn_n = 1; bp_en = 0; bp_addr = 0;
        pc = 0; endcontrol = 0; clr_cnt = 0; pc_follow = 0;
        model_reset();
        repeat (3) tick();
        reset_n = 1;
    endtask

    task automatic hold_btn(input bit lvl, input int n);
        step_btn_n = lvl;
        repeat (n) tick();
    endtask

    int snap;

    initial begin
        // ---- Reset / HALT ----
        apply_reset();
        ce_seen = 0;
        repeat (20) tick();
        check("halt_ce_pulses", ce_seen, 0);
        check("halt_count", cycle_count, 0);
        check("halt_state", state, 0);
        check("halt_halted", halted, 1);
        check("halt_bp_hit", bp_hit, 0);

        // ---- RUN + clear + saturation ----
        apply_reset();
        ce_seen = 0;
        mode = 2'd1;
        repeat (10) tick();
        mode = 2'd0;
        repeat (3) tick();
        check("run_pulses", ce_seen, 10);
        check("run_count", cycle_count, 10);
        mode = 2'd1;
        repeat (3) tick();
        clr_cnt = 1;
        tick();
        check("clr_wins", cycle_count, 0);
        clr_cnt = 0;
        tick();
        check("clr_recount", cycle_count, 1);
        repeat (20) tick();
        check("count_saturate", cycle_count, MAXC);

        // ---- SLOW ----
        apply_reset();
        ce_seen = 0;
        mode = 2'd2;
        for (int i = 0; i < 19; i++) begin
            if (i == 16) mode = 2'd0;
            tick();
            if (cpu_ce && ce_seen > 1) check("slow_gap", ce_gap, DIV);
        end
        check("slow_pulses", ce_seen, 4);
        check("slow_count", cycle_count, 4);

        // ---- STEP + debounce ----
        apply_reset();
        mode = 2'd3;
        repeat (2) tick();
        ce_seen = 0;
        hold_btn(0, 2);
        hold_btn(1, 10);
        check("glitch_no_pulse", ce_seen, 0);
        hold_btn(0, 10);
        hold_btn(1, 10);
        check("step_pulses", ce_seen, 1);
        check("step_count1", cycle_count, 1);
        hold_btn(0, 10);
        hold_btn(1, 10);
        check("step_count2", cycle_count, 2);

        // ---- Breakpoint ----
        apply_reset();
        bp_en = 1; bp_addr = 32'h10; mode = 2'd1;
        repeat (3) tick();
        pc = 32'h10;
        tick();
        check("bp_state", state, 4);
        check("bp_hit", bp_hit, 1);
        check("bp_ce", cpu_ce, 0);
        repeat (5) tick();
        check("bp_hold_ce", cpu_ce, 0);
        snap = int'(cycle_count);
        mode = 2'd3; pc_follow = 1; ce_seen = 0;
        hold_btn(0, 8);
        hold_btn(1, 8);
        check("bp_step_pulses", ce_seen, 1);
        check("bp_step_count", cycle_count, snap + 1);
        check("bp_no_retrigger", state, 3);
        pc_follow = 0;

        // ---- End / DONE ----
        apply_reset();
        mode = 2'd1;
        repeat (5) tick();
        endcontrol = 1;
        tick();
        check("done_state", state, 5);
        check("done_ce", cpu_ce, 0);
        endcontrol = 0;
        repeat (2) tick();
        snap = int'(cycle_count);
        ce_seen = 0;
        mode = 2'd2;
        repeat (10) tick();
        check("done_sticky", state, 5);
        check("done_frozen", cycle_count, snap);
        check("done_no_pulse", ce_seen, 0);

        // ---- Asynchronous reset mid-RUN ----
        apply_reset();
        mode = 2'd1;
        repeat (5) tick();
        reset_n = 0;
        #1;
        check("areset_ce", cpu_ce, 0);
        check("areset_count", cycle_count, 0);
        check("areset_state", state, 0);
        check("areset_halted", halted, 1);
        check("areset_bp_hit", bp_hit, 0);
        model_reset();
        apply_reset();

        // ---- Randomized stimulus against the model ----
        pc_follow = 1;
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 14) == 0) begin
                apply_reset();
                pc_follow = 1;
            end
            mode    = 2'($urandom_range(0, 3));
            bp_en   = ($urandom_range(0, 2) != 0);
            bp_addr = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 4) == 0) pc = 32'($urandom_range(0, 15)) << 2;
            for (int k = 0, n = int'($urandom_range(1, 40)); k < n; k++) begin
                if ($urandom_range(0, 7) == 0) step_btn_n = ~step_btn_n;
                clr_cnt    = ($urandom_range(0, 19) == 0);
                endcontrol = ($urandom_range(0, 399) == 0);
                tick();
            end
            clr_cnt = 0; endcontrol = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
